stopwatch_mux: RTL and testbench

Parametrised MM:SS stopwatch with time-multiplexed 4-digit seven-segment drive, pause control and an adjust mode that sets minutes or seconds with a blinking selected field. It sits at the top of the lab design, between the debounced button/switch inputs and the board's `seg`/`an` pins. It replaces the constant-`0` display stub.

---
 rtl/stopwatch_mux.sv | 201 ++++++++++++++++++++
 tb/tb_stopwatch_mux.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_mux.sv
// MM:SS stopwatch with pause, adjust mode and a blinking
// field, driving a 4-digit multiplexed seven-segment display.
module stopwatch_mux #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1,
  parameter int ADJ_HZ     = 2,
  parameter int REFRESH_HZ = 500,
  parameter int BLINK_HZ   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pause_p,
  input  logic        clr,
  input  logic        adj,
  input  logic        sel,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic [15:0] value
);

  localparam int D_CNT = CLK_HZ / TICK_HZ;
  localparam int D_ADJ = CLK_HZ / ADJ_HZ;
  localparam int D_REF = CLK_HZ / (4 * REFRESH_HZ);
  localparam int D_BLK = CLK_HZ / (2 * BLINK_HZ);
  localparam int W_CNT = $clog2(D_CNT);
  localparam int W_ADJ = $clog2(D_ADJ);
  localparam int W_REF = $clog2(D_REF);
  localparam int W_BLK = $clog2(D_BLK);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_PAUSED = 1'b1;

  logic [0:0]       r_state;
  logic [W_CNT-1:0] r_cnt_div;
  logic [W_ADJ-1:0] r_adj_div;
  logic [W_REF-1:0] r_ref_div;
  logic [W_BLK-1:0] r_blk_div;
  logic [1:0]       r_idx;
  logic             r_blink;
  logic [15:0]      r_value;
  logic [7:0]       r_seg;
  logic [3:0]       r_an;

  logic       w_run;
  logic       w_tick;
  logic       w_atick;
  logic       w_rtick;
  logic       w_btick;
  logic [7:0] w_sec_nx;
  logic       w_sec_wrap;
  logic [7:0] w_min_nx;
  logic [3:0] w_digit;
  logic       w_hide;

  assign w_run   = (r_state == ST_RUN);
  assign w_tick  = w_run & ~adj
                 & (r_cnt_div == W_CNT'(D_CNT - 1));
  assign w_atick = adj & (r_adj_div == W_ADJ'(D_ADJ - 1));
  assign w_rtick = (r_ref_div == W_REF'(D_REF - 1));
  assign w_btick = (r_blk_div == W_BLK'(D_BLK - 1));

  // Per-digit BCD successors; S1 rolls at 5, M1 at 9
  always_comb begin
    w_sec_nx   = r_value[7:0];
    w_sec_wrap = 1'b0;
    if (r_value[3:0] == 4'd9) begin
      w_sec_nx[3:0] = 4'd0;
      if (r_value[7:4] >= 4'd5) begin
        w_sec_nx[7:4] = 4'd0;
        w_sec_wrap    = 1'b1;
      end else begin
        w_sec_nx[7:4] = r_value[7:4] + 4'd1;
      end
    end else begin
      w_sec_nx[3:0] = r_value[3:0] + 4'd1;
    end
  end

  always_comb begin
    w_min_nx = r_value[15:8];
    if (r_value[11:8] == 4'd9) begin
      w_min_nx[3:0] = 4'd0;
      if (r_value[15:12] >= 4'd9)
        w_min_nx[7:4] = 4'd0;
      else
        w_min_nx[7:4] = r_value[15:12] + 4'd1;
    end else begin
      w_min_nx[3:0] = r_value[11:8] + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else if (pause_p) begin
      r_state <= w_run ? ST_PAUSED : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_div <= '0;
      r_adj_div <= '0;
      r_value   <= '0;
    end else if (clr) begin
      r_cnt_div <= '0;
      r_adj_div <= '0;
      r_value   <= '0;
    end else begin
      if (w_run && !adj)
        r_cnt_div <= w_tick ? '0 : r_cnt_div + 1'b1;
      if (!adj)
        r_adj_div <= '0;
      else
        r_adj_div <= w_atick ? '0 : r_adj_div + 1'b1;
      if (w_atick) begin
        if (sel)
          r_value <= {r_value[15:8], w_sec_nx};
        else
          r_value <= {w_min_nx, r_value[7:0]};
      end else if (w_tick) begin
        if (w_sec_wrap)
          r_value <= {w_min_nx, 8'h00};
        else
          r_value <= {r_value[15:8], w_sec_nx};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_div <= '0;
      r_idx     <= 2'd0;
    end else if (w_rtick) begin
      r_ref_div <= '0;
      r_idx     <= r_idx + 2'd1;
    end else begin
      r_ref_div <= r_ref_div + 1'b1;
    end
  end

  // Blink phase restarts "on" each time adjust mode is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_div <= '0;
      r_blink   <= 1'b1;
    end else if (!adj) begin
      r_blk_div <= '0;
      r_blink   <= 1'b1;
    end else if (w_btick) begin
      r_blk_div <= '0;
      r_blink   <= ~r_blink;
    end else begin
      r_blk_div <= r_blk_div + 1'b1;
    end
  end

  function automatic logic [6:0] f_dec(input logic [3:0] d);
    case (d)
      4'd0:    f_dec = 7'b1000000;
      4'd1:    f_dec = 7'b1111001;
      4'd2:    f_dec = 7'b0100100;
      4'd3:    f_dec = 7'b0110000;
      4'd4:    f_dec = 7'b0011001;
      4'd5:    f_dec = 7'b0010010;
      4'd6:    f_dec = 7'b0000010;
      4'd7:    f_dec = 7'b1111000;
      4'd8:    f_dec = 7'b0000000;
      4'd9:    f_dec = 7'b0010000;
      default: f_dec = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    w_digit = r_value[3:0];
    unique case (1'b1)
      r_idx == 2'd0: w_digit = r_value[3:0];
      r_idx == 2'd1: w_digit = r_value[7:4];
      r_idx == 2'd2: w_digit = r_value[11:8];
      r_idx == 2'd3: w_digit = r_value[15:12];
    endcase
  end

  assign w_hide = adj & ~r_blink
                & (sel ? ~r_idx[1] : r_idx[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= 8'b11000000;
      r_an  <= 4'b1110;
    end else begin
      r_seg <= {(r_idx != 2'd2), f_dec(w_digit)};
      r_an  <= w_hide ? 4'b1111 : ~(4'b0001 << r_idx);
    end
  end

  assign seg   = r_seg;
  assign an    = r_an;
  assign value = r_value;

endmodule

// File: tb/tb_stopwatch_mux.sv
// Bench for stopwatch_mux: time-based reference model checked
// every cycle plus hand-computed literal expectations.
module tb_stopwatch_mux;

  localparam int CLK = 1000;
  localparam int DC  = 10;
  localparam int DA  = 20;
  localparam int DR  = 5;
  localparam int DB  = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pause_p = 1'b0;
  logic        clr = 1'b0;
  logic        adj = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [15:0] value;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  stopwatch_mux #(
    .CLK_HZ(CLK), .TICK_HZ(100), .ADJ_HZ(50),
    .REFRESH_HZ(50), .BLINK_HZ(25)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pause_p(pause_p),
    .clr(clr), .adj(adj), .sel(sel),
    .seg(seg), .an(an), .value(value)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000
  };

  // Model: time in minutes/seconds, dividers as elapsed cycle counts
  int m_min = 0, m_sec = 0, m_frac = 0, m_afrac = 0;
  int m_edges = 0, m_alen = 0;
  bit m_run = 1'b1;
  logic [15:0] e_value = '0;
  logic [3:0]  e_an = 4'b1110;
  logic [7:0]  e_seg = 8'b11000000;

  always @(posedge clk or negedge rst_n) begin
    int idx, dig;
    bit on, hide;
    if (!rst_n) begin
      m_min = 0; m_sec = 0; m_frac = 0; m_afrac = 0;
      m_edges = 0; m_alen = 0; m_run = 1'b1;
      e_value = '0; e_an = 4'b1110; e_seg = 8'b11000000;
    end else begin
      idx = (m_edges / DR) % 4;
      on  = ((m_alen / DB) % 2) == 0;
      case (idx)
        0: dig = m_sec % 10;
        1: dig = m_sec / 10;
        2: dig = m_min % 10;
        default: dig = m_min / 10;
      endcase
      e_seg = {(idx != 2), seg_tab[dig]};
      hide = adj && !on && (sel ? (idx < 2) : (idx >= 2));
      e_an = hide ? 4'b1111 : ~(4'(1) << idx);
      if (clr) begin
        m_min = 0; m_sec = 0; m_frac = 0; m_afrac = 0;
      end else if (adj) begin
        m_afrac++;
        if (m_afrac == DA) begin
          m_afrac = 0;
          if (sel) m_sec = (m_sec + 1) % 60;
          else     m_min = (m_min + 1) % 100;
        end
      end else if (m_run) begin
        m_frac++;
        if (m_frac == DC) begin
          m_frac = 0;
          m_sec++;
          if (m_sec == 60) begin
            m_sec = 0;
            m_min = (m_min + 1) % 100;
          end
        end
      end
      if (!adj) m_afrac = 0;
      if (pause_p) m_run = !m_run;
      m_edges++;
      m_alen = adj ? m_alen + 1 : 0;
      e_value = 16'(((m_min / 10) << 12) | ((m_min % 10) << 8)
              | ((m_sec / 10) << 4) | (m_sec % 10));
    end
  end

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_value", value, e_value);
      chk("model_an", 16'(an), 16'(e_an));
      chk("model_seg", 16'(seg), 16'(e_seg));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_pause();
    pause_p = 1'b1;
    cyc(1);
    pause_p = 1'b0;
  endtask

  bit seen_m1, seen_m0;

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk_en = 1'b1;
    chk("rst_an", 16'(an), 16'h000E);
    chk("rst_seg", 16'(seg), 16'h00C0);
    chk("rst_value", value, 16'h0000);
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    chk("first_tick", value, 16'h0001);
    cyc(580);
    chk("at_0059", value, 16'h0059);
    cyc(10);
    chk("carry_0100", value, 16'h0100);

    cyc(34);
    chk("pre_pause", value, 16'h0103);
    pulse_pause();
    cyc(100);
    chk("paused_hold", value, 16'h0103);
    pulse_pause();
    cyc(4);
    chk("resume_no_extra", value, 16'h0103);
    cyc(1);
    chk("resume_tick", value, 16'h0104);

    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_zero", value, 16'h0000);
    cyc(580);
    chk("at_0058", value, 16'h0058);
    adj = 1'b1;
    sel = 1'b1;
    cyc(20);
    chk("adj_sec_59", value, 16'h0059);
    cyc(20);
    chk("adj_sec_wrap", value, 16'h0000);

    sel = 1'b0;
    cyc(240);
    adj = 1'b0;
    chk("adj_min_12", value, 16'h1200);
    seen_m1 = 1'b0;
    seen_m0 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (an == 4'b0111 && seg[6:0] == 7'b1111001)
        seen_m1 = 1'b1;
      if (an == 4'b1011 && seg == 8'b00100100)
        seen_m0 = 1'b1;
    end
    cyc(1);
    chk("scan_m1", 16'(seen_m1), 16'h0001);
    chk("scan_m0_dp", 16'(seen_m0), 16'h0001);

    for (int i = 0; i < 3000; i++) begin
      pause_p = ($urandom_range(49) == 0);
      clr = ($urandom_range(299) == 0);
      if ($urandom_range(99) == 0) adj = ~adj;
      if ($urandom_range(29) == 0) sel = ~sel;
      cyc(1);
    end
    pause_p = 1'b0;
    adj = 1'b0;
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    if (!m_run) pulse_pause();
    chk("wrap_start", value, 16'h0000);
    adj = 1'b1;
    sel = 1'b0;
    cyc(99 * DA);
    sel = 1'b1;
    cyc(59 * DA);
    adj = 1'b0;
    chk("at_9959", value, 16'h9959);
    cyc(DC);
    chk("wrap_0000", value, 16'h0000);

    cyc(227 * DC);
    chk("at_0347", value, 16'h0347);
    clr = 1'b1;
    pause_p = 1'b1;
    cyc(1);
    clr = 1'b0;
    pause_p = 1'b0;
    chk("clr_pause_zero", value, 16'h0000);
    cyc(30);
    chk("clr_paused_hold", value, 16'h0000);
    pulse_pause();
    cyc(27);
    chk("resumed_0002", value, 16'h0002);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", 16'(an), 16'h000E);
    chk("async_seg", 16'(seg), 16'h00C0);
    chk("async_value", value, 16'h0000);
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    chk("post_rst_tick", value, 16'h0001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
